// File: rtl/gen_layer_scheduler_if.sv
// Handshake bundle between the GAN controller, the scheduler and the layer chain.
interface gen_layer_scheduler_if #(
  parameter int NUM_LAYERS = 3
);
  logic                  req;
  logic                  req_ready;
  logic                  abort;
  logic [NUM_LAYERS-1:0] layer_start;
  logic [NUM_LAYERS-1:0] layer_done;
  logic                  capture_en;
  logic [2:0]            capture_sel;
  logic [2:0]            active_layer;
  logic                  busy;
  logic                  frame_done;
  logic                  timeout_err;
  logic [2:0]            err_layer;
  logic [31:0]           frame_cycles;

  // Scheduler side
  modport slave (
    input  req, abort, layer_done,
    output req_ready, layer_start, capture_en, capture_sel, active_layer,
           busy, frame_done, timeout_err, err_layer, frame_cycles
  );

  // Controller / layer-chain side
  modport master (
    output req, abort, layer_done,
    input  req_ready, layer_start, capture_en, capture_sel, active_layer,
           busy, frame_done, timeout_err, err_layer, frame_cycles
  );
endinterface

// File: rtl/gen_layer_scheduler.sv
// Layer sequencer: launches each generator layer in turn, strobes capture on
// done, traps hung layers with a watchdog and measures whole-frame latency.
// Every output is a flop loaded from the next-state decode, so outputs line up
// with the state they describe and no input reaches an output combinationally.
module gen_layer_scheduler #(
  parameter int NUM_LAYERS     = 3,
  parameter int TIMEOUT_CYCLES = 262143,
  parameter int WD_W           = 18
) (
  input  logic                clk,
  input  logic                rst_n,
  gen_layer_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_CAPTURE, S_FINISH, S_ERROR
  } state_t;

  localparam logic [2:0]      LAST_IDX = 3'(NUM_LAYERS - 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [31:0]           fcnt_q, fcnt_d;
  logic [2:0]            err_layer_q, err_layer_d;
  logic [31:0]           frame_cycles_q, frame_cycles_d;

  logic                  req_ready_q, req_ready_d;
  logic [NUM_LAYERS-1:0] layer_start_q, layer_start_d;
  logic                  capture_en_q, capture_en_d;
  logic [2:0]            capture_sel_q, capture_sel_d;
  logic [2:0]            active_layer_q, active_layer_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  timeout_err_q, timeout_err_d;

  logic                  done_sel;
  logic                  in_layer_d;

  // Pick out only the current layer's done bit; all others are ignored
  always_comb begin
    done_sel = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++)
      if (idx_q == 3'(i)) done_sel = done_sel | bus.layer_done[i];
  end

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    wd_d           = wd_q;
    fcnt_d         = fcnt_q;
    err_layer_d    = err_layer_q;
    frame_cycles_d = frame_cycles_q;

    // Frame counter runs from LAUNCH of layer 0 through the last CAPTURE
    if ((state_q == S_LAUNCH || state_q == S_WAIT || state_q == S_CAPTURE) &&
        fcnt_q != 32'hFFFF_FFFF)
      fcnt_d = fcnt_q + 32'd1;

    case (state_q)
      S_IDLE: if (bus.req) begin
        idx_d       = 3'd0;
        wd_d        = '0;
        fcnt_d      = 32'd0;
        err_layer_d = 3'd0;
        state_d     = S_LAUNCH;
      end
      S_LAUNCH: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done beats a timeout landing on the same cycle
        if (done_sel) state_d = S_CAPTURE;
        else if (wd_q == WD_LAST) begin
          state_d     = S_ERROR;
          err_layer_d = idx_q;
        end else wd_d = wd_q + 1'b1;
      end
      S_CAPTURE: begin
        if (idx_q == LAST_IDX) state_d = S_FINISH;
        else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_LAUNCH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_IDLE;
    endcase

    // Abort overrides any transition and leaves the error record intact
    if (bus.abort) begin
      state_d     = S_IDLE;
      err_layer_d = err_layer_q;
    end

    if (state_d == S_FINISH) frame_cycles_d = fcnt_d;

    in_layer_d     = (state_d == S_LAUNCH) || (state_d == S_WAIT) ||
                     (state_d == S_CAPTURE);
    req_ready_d    = (state_d == S_IDLE);
    busy_d         = (state_d != S_IDLE) && (state_d != S_ERROR);
    capture_en_d   = (state_d == S_CAPTURE);
    capture_sel_d  = (state_d == S_CAPTURE) ? idx_d : 3'd0;
    active_layer_d = in_layer_d ? idx_d : 3'd0;
    frame_done_d   = (state_d == S_FINISH);
    timeout_err_d  = (state_d == S_ERROR);
    for (int i = 0; i < NUM_LAYERS; i++)
      layer_start_d[i] = (state_d == S_LAUNCH) && (idx_d == 3'(i));
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      idx_q          <= 3'd0;
      wd_q           <= '0;
      fcnt_q         <= 32'd0;
      err_layer_q    <= 3'd0;
      frame_cycles_q <= 32'd0;
      req_ready_q    <= 1'b1;
      layer_start_q  <= '0;
      capture_en_q   <= 1'b0;
      capture_sel_q  <= 3'd0;
      active_layer_q <= 3'd0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      wd_q           <= wd_d;
      fcnt_q         <= fcnt_d;
      err_layer_q    <= err_layer_d;
      frame_cycles_q <= frame_cycles_d;
      req_ready_q    <= req_ready_d;
      layer_start_q  <= layer_start_d;
      capture_en_q   <= capture_en_d;
      capture_sel_q  <= capture_sel_d;
      active_layer_q <= active_layer_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.layer_start  = layer_start_q;
  assign bus.capture_en   = capture_en_q;
  assign bus.capture_sel  = capture_sel_q;
  assign bus.active_layer = active_layer_q;
  assign bus.busy         = busy_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.err_layer    = err_layer_q;
  assign bus.frame_cycles = frame_cycles_q;

endmodule

// File: tb/tb_gen_layer_scheduler.sv
// Directed bench for gen_layer_scheduler (3 layers, 16-cycle watchdog).
module tb_gen_layer_scheduler;
  localparam int NL = 3;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;

  gen_layer_scheduler_if #(.NUM_LAYERS(NL)) bus ();

  gen_layer_scheduler #(
    .NUM_LAYERS(NL), .TIMEOUT_CYCLES(16), .WD_W(18)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered with layer i's LAUNCH visible; returns with the following state visible.
  task automatic run_layer(input int i, input int lat);
    chk("layer_start", 32'(bus.layer_start), 32'(1 << i));
    chk("active_layer", 32'(bus.active_layer), 32'(i));
    step();
    for (int k = 1; k < lat; k++) step();
    chk("no_early_capture", 32'(bus.capture_en), 32'd0);
    bus.layer_done = NL'(1 << i);
    step();
    bus.layer_done = '0;
    chk("capture_en", 32'(bus.capture_en), 32'd1);
    chk("capture_sel", 32'(bus.capture_sel), 32'(i));
    step();
  endtask

  task automatic run_frame(input int l0, input int l1, input int l2, input int exp_cyc);
    run_layer(0, l0);
    run_layer(1, l1);
    run_layer(2, l2);
    chk("frame_done", 32'(bus.frame_done), 32'd1);
    chk("frame_cycles", bus.frame_cycles, 32'(exp_cyc));
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst_n = 1'b0;
    bus.req = 1'b0;
    bus.abort = 1'b0;
    bus.layer_done = '0;
    #12;
    // Reset state
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_layer_start", 32'(bus.layer_start), 32'd0);
    chk("rst_frame_cycles", bus.frame_cycles, 32'd0);
    rst_n = 1'b1;
    step();

    // Nominal frame: 5,7,3 -> 7+9+5 = 21
    bus.req = 1'b1;
    step();
    bus.req = 1'b0;
    chk("acc_req_ready", 32'(bus.req_ready), 32'd0);
    chk("acc_busy", 32'(bus.busy), 32'd1);
    run_frame(5, 7, 3, 21);
    step();
    chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
    chk("idle_frame_done", 32'(bus.frame_done), 32'd0);
    chk("idle_active", 32'(bus.active_layer), 32'd0);

    // Back-to-back with req held high
    bus.req = 1'b1;
    step();
    run_frame(2, 4, 1, 13);
    step();
    chk("b2b_idle", 32'(bus.req_ready), 32'd1);
    step();
    chk("b2b_restart", 32'(bus.layer_start), 32'd1);
    bus.req = 1'b0;
    run_frame(2, 4, 1, 13);
    step();

    // Timeout on layer 1
    bus.req = 1'b1;
    step();
    bus.req = 1'b0;
    run_layer(0, 2);
    chk("to_launch1", 32'(bus.layer_start), 32'b010);
    step();
    for (int k = 1; k < 16; k++) step();
    chk("to_not_yet", 32'(bus.timeout_err), 32'd0);
    step();
    chk("to_err", 32'(bus.timeout_err), 32'd1);
    chk("to_err_layer", 32'(bus.err_layer), 32'd1);
    chk("to_busy", 32'(bus.busy), 32'd0);
    bus.req = 1'b1;
    step();
    step();
    chk("to_req_ignored", 32'(bus.req_ready), 32'd0);
    chk("to_still_err", 32'(bus.timeout_err), 32'd1);
    bus.req = 1'b0;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("to_abort_ready", 32'(bus.req_ready), 32'd1);
    chk("to_abort_clr", 32'(bus.timeout_err), 32'd0);
    chk("to_err_kept", 32'(bus.err_layer), 32'd1);
    chk("to_fc_kept", bus.frame_cycles, 32'd13);

    // Done on the final watchdog cycle: 18 + 3 + 18 = 39
    bus.req = 1'b1;
    step();
    bus.req = 1'b0;
    chk("col_err_clr", 32'(bus.err_layer), 32'd0);
    run_frame(16, 1, 16, 39);
    chk("col_no_err", 32'(bus.timeout_err), 32'd0);
    step();

    // Spurious done and abort
    bus.req = 1'b1;
    step();
    bus.req = 1'b0;
    step();
    bus.layer_done = 3'b100;
    step();
    bus.layer_done = '0;
    chk("spur_no_cap", 32'(bus.capture_en), 32'd0);
    chk("spur_busy", 32'(bus.busy), 32'd1);
    chk("spur_active", 32'(bus.active_layer), 32'd0);
    bus.layer_done = 3'b001;
    step();
    bus.layer_done = '0;
    chk("spur_cap", 32'(bus.capture_en), 32'd1);
    step();
    chk("ab_launch1", 32'(bus.layer_start), 32'b010);
    step();
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("ab_ready", 32'(bus.req_ready), 32'd1);
    chk("ab_busy", 32'(bus.busy), 32'd0);
    chk("ab_no_cap", 32'(bus.capture_en), 32'd0);
    chk("ab_fc_kept", bus.frame_cycles, 32'd39);
    step();
    chk("ab_no_start", 32'(bus.layer_start), 32'd0);

    // Async reset during CAPTURE
    bus.req = 1'b1;
    step();
    bus.req = 1'b0;
    step();
    bus.layer_done = 3'b001;
    step();
    bus.layer_done = '0;
    chk("ar_in_capture", 32'(bus.capture_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req_ready", 32'(bus.req_ready), 32'd1);
    chk("ar_capture", 32'(bus.capture_en), 32'd0);
    chk("ar_busy", 32'(bus.busy), 32'd0);
    chk("ar_active", 32'(bus.active_layer), 32'd0);
    chk("ar_fc", bus.frame_cycles, 32'd0);
    chk("ar_start", 32'(bus.layer_start), 32'd0);
    #2 rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/gen_layer_scheduler.md
# gen_layer_scheduler

Sequencing controller for the generator datapath. It accepts one frame request and launches the fully-connected generator layers in order, one `start` pulse per layer. Each layer's `done` pulse is answered with a capture strobe that latches that layer's output bus into the next stage's activation register. A per-layer watchdog traps hung layers, and the block reports whole-frame latency. It sits between the top-level GAN controller and the chain of `layerN_generator` instances.

## Interface
- `NUM_LAYERS`, default 3: number of sequenced layers, valid range 1..8.
- `TIMEOUT_CYCLES`, default 262143: maximum WAIT cycles per layer before trapping. Must be ≥2 and < 2^`WD_W`.
- `WD_W`, default 18: watchdog counter width.

- `clk`, input, 1: single clock; all flops on rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, 1: frame request; accepted when `req && req_ready`.
- `req_ready`, output, 1: high only in IDLE.
- `abort`, input, 1: synchronous abort; forces IDLE.
- `layer_start`, output, `NUM_LAYERS`: one-hot, single-cycle start pulse to layer *i*.
- `layer_done`, input, `NUM_LAYERS`: done pulses from the layers.
- `capture_en`, output, 1: single-cycle strobe to latch the selected layer's output.
- `capture_sel`, output, 3: index of the layer being captured; valid while `capture_en` is high.
- `active_layer`, output, 3: current layer index; 0 when idle.
- `busy`, output, 1: high in any state except IDLE and ERROR.
- `frame_done`, output, 1: single-cycle pulse when a frame completes.
- `timeout_err`, output, 1: high while in ERROR.
- `err_layer`, output, 3: index of the layer that timed out; held until the next accepted `req`.
- `frame_cycles`, output, 32: cycles from accept to `frame_done` for the last completed frame.

## Operation
- All outputs are driven from flops or decoded from the state register only. There is no combinational path from any input to any output.
- Reset value of every output is 0, except `req_ready`, which resets to 1. State resets to IDLE.
- State machine:
  - **IDLE**: on `req`, clear the layer index, the watchdog and the frame counter, clear `err_layer`, then go to LAUNCH.
  - **LAUNCH** (1 cycle): `layer_start[idx]` = 1. Clear the watchdog, then go to WAIT.
  - **WAIT**:
    - Watchdog increments each cycle.
    - `layer_done[idx]` → CAPTURE.
    - Watchdog == `TIMEOUT_CYCLES`-1 with no done → ERROR, and `err_layer` ← idx.
    - Done and timeout in the same cycle: done wins.
    - `layer_done` bits for other layers are ignored in every state.
  - **CAPTURE** (1 cycle): `capture_en` = 1 and `capture_sel` = idx.
    - If idx == `NUM_LAYERS`-1, go to FINISH.
    - Otherwise idx increments and the next state is LAUNCH.
  - **FINISH** (1 cycle): `frame_done` = 1, `frame_cycles` ← frame counter, then go to IDLE.
  - **ERROR**: `timeout_err` = 1. Stays here until `abort` or reset; `req` is ignored.
- `abort` takes priority over every transition in every state:
  - Next state is IDLE.
  - No further `layer_start`, `capture_en` or `frame_done` pulses are issued.
  - `frame_cycles` is left unchanged.
  - `err_layer` is kept.
- Frame counter:
  - 32-bit, saturating at 0xFFFFFFFF.
  - Counts every cycle from LAUNCH of layer 0 through CAPTURE of the last layer, inclusive.
- `req` held high continuously: a new frame is accepted on the cycle the block returns to IDLE.
- `active_layer` follows idx in LAUNCH, WAIT and CAPTURE; it is 0 elsewhere.

## Timing
- Accept at edge E0 → `layer_start[0]` high during the cycle E0→E1.
- `layer_done` sampled high at edge Ed → `capture_en` high for the cycle after Ed.
- Next layer's `layer_start` follows `capture_en` by exactly 1 cycle.
- Per-layer overhead is 2 cycles (LAUNCH + CAPTURE) plus the layer's own latency, counted from start to done, inclusive of the done cycle.
- `frame_cycles` = Σ(layer latency_i + 2), where layer latency_i is the number of cycles spent in WAIT for layer *i* (the first WAIT cycle through the cycle on which done is sampled).
- `frame_done` arrives 1 cycle after the last `capture_en`. `req_ready` rises on the cycle after `frame_done`.
- Timeout detection: ERROR is entered exactly `TIMEOUT_CYCLES` cycles after LAUNCH exits.
- `rst_n` deassertion carries no synchronizer requirement inside this block; the top level provides the synchronized release.

## Test plan
- **Nominal frame**: `NUM_LAYERS`=3; stub layers return done after 5, 7 and 3 WAIT cycles.
  - Expect `layer_start` = 001, 010, 100 in order.
  - Expect 3 `capture_en` pulses with `capture_sel` = 0, 1, 2.
  - Expect `frame_done` once, and `frame_cycles` = 21.
- **Back-to-back**: `req` held high for 2 frames.
  - Second `layer_start[0]` appears exactly 2 cycles after the first `frame_done`.
  - `frame_cycles` is identical for both frames.
- **Timeout**: `TIMEOUT_CYCLES`=16; layer 1 never returns done.
  - `timeout_err` rises 16 cycles after WAIT is entered, with `err_layer` = 1.
  - `req` is ignored.
  - `abort` returns the block to IDLE with `req_ready` = 1.
- **Done/timeout collision**: done arrives on the final watchdog cycle.
  - Expect CAPTURE, not ERROR.
- **Spurious and abort**:
  - `layer_done[2]` pulsed during layer 0's WAIT is ignored.
  - `abort` during layer 1's WAIT → IDLE next cycle; no `capture_en`; `frame_cycles` unchanged.
- **Async reset mid-frame**: drop `rst_n` during CAPTURE with no clock edge.
  - All outputs go to reset values immediately: `req_ready` = 1, everything else 0.
